script_sequencer: RTL and testbench

Fetch/execute controller for kitchen scripts. It steps a program counter through the script ROM and decodes each 16-bit instruction: i_num = [15:8], i_sign = [7:5], fun = [4:3], op_code = [2:0]. It resolves Jump and Wait locally against game-state condition bits. Action and Game State instructions go out as commands over a valid/ready channel to the command/UART output path.

---
 rtl/script_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_script_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/script_sequencer.sv
// Fetch/execute controller for kitchen scripts: walks the script ROM, resolves jumps and
// waits locally, and hands Action / Game State instructions to the command channel.
module script_sequencer #(
   parameter int TICK_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [15:0]       rom_data,
   input  logic [7:0]        cond,
   input  logic              tick,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [2:0]        cmd_op,
   output logic [1:0]        cmd_fun,
   output logic [7:0]        cmd_arg,
   output logic              busy,
   output logic              halted
);

   // state  | meaning
   // IDLE   | stopped or never started; waits for start
   // FETCH  | rom_addr = pc, ROM word arrives next cycle
   // EXEC   | decode rom_data, resolve jump / wait / command
   // ISSUE  | command held on the channel until cmd_ready
   // WAIT_T | counting ticks down to terminal count 1
   // WAIT_C | waiting for cond[csel] to reach the wanted level
   // HALT   | script ended; start re-runs from address 0
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_ISSUE, S_WAIT_T, S_WAIT_C, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [2:0]        cmd_op_q, cmd_op_d;
   logic [1:0]        cmd_fun_q, cmd_fun_d;
   logic [7:0]        cmd_arg_q, cmd_arg_d;
   logic [2:0]        csel_q, csel_d;
   logic              cpol_q, cpol_d;
   logic              stop_pend_q, stop_pend_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;

   logic [7:0] i_num;
   logic [2:0] i_sign;
   logic [1:0] fun;
   logic [2:0] op_code;
   logic       issue_cmd;
   logic       end_game;

   assign i_num    = rom_data[15:8];
   assign i_sign   = rom_data[7:5];
   assign fun      = rom_data[4:3];
   assign op_code  = rom_data[2:0];
   assign pc_inc   = pc_q + PC_W'(1);
   assign end_game = (cmd_op_q == 3'b100) && (cmd_fun_q == 2'b01);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_fun_d   = cmd_fun_q;
      cmd_arg_d   = cmd_arg_q;
      csel_d      = csel_q;
      cpol_d      = cpol_q;
      stop_pend_d = stop_pend_q;
      issue_cmd   = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = S_FETCH;
               pc_d    = pc_inc;
               case (op_code)
                  3'b000: begin
                     state_d = S_HALT;
                     pc_d    = pc_q;
                  end
                  3'b001: issue_cmd = 1'b1;
                  3'b010: begin
                     case (fun)
                        2'b00:   if (cond[i_sign])  pc_d = PC_W'(i_num);
                        2'b01:   if (!cond[i_sign]) pc_d = PC_W'(i_num);
                        2'b10:   pc_d = PC_W'(i_num);
                        default: ;
                     endcase
                  end
                  3'b011: begin
                     case (fun)
                        2'b00: begin
                           if (i_num != 8'd0) begin
                              cnt_d   = TICK_W'(i_num);
                              state_d = S_WAIT_T;
                              pc_d    = pc_q;
                           end
                        end
                        2'b01, 2'b10: begin
                           csel_d  = i_sign;
                           cpol_d  = (fun == 2'b01);
                           state_d = S_WAIT_C;
                           pc_d    = pc_q;
                        end
                        default: ;
                     endcase
                  end
                  3'b100:  issue_cmd = !fun[1];
                  default: ;
               endcase
               if (issue_cmd) begin
                  cmd_valid_d = 1'b1;
                  cmd_op_d    = op_code;
                  cmd_fun_d   = fun;
                  cmd_arg_d   = i_num;
                  state_d     = S_ISSUE;
                  pc_d        = pc_q;
               end
            end
         end
         S_ISSUE: begin
            // The handshake is never abandoned; a stop is remembered until the accept.
            if (stop) stop_pend_d = 1'b1;
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               pc_d        = pc_inc;
               stop_pend_d = 1'b0;
               if (stop || stop_pend_q) state_d = S_IDLE;
               else if (end_game)       state_d = S_HALT;
               else                     state_d = S_FETCH;
            end
         end
         S_WAIT_T: begin
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == TICK_W'(1)) begin
                  cnt_d   = '0;
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end else begin
                  cnt_d = cnt_q - TICK_W'(1);
               end
            end
         end
         S_WAIT_C: begin
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cond[csel_q] == cpol_q) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= '0;
         cmd_fun_q   <= '0;
         cmd_arg_q   <= '0;
         csel_q      <= '0;
         cpol_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_fun_q   <= cmd_fun_d;
         cmd_arg_q   <= cmd_arg_d;
         csel_q      <= csel_d;
         cpol_q      <= cpol_d;
         stop_pend_q <= stop_pend_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign rom_addr  = pc_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_fun   = cmd_fun_q;
   assign cmd_arg   = cmd_arg_q;
   assign busy      = busy_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_script_sequencer.sv
// Bench for script_sequencer: directed timing scenarios plus random scripts checked against
// a plain script interpreter; a negedge monitor scores every accepted command.
module tb_script_sequencer;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] fun;
      logic [7:0] arg;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst, start, stop, tick, cmd_ready;
   logic [7:0]  cond;
   logic [15:0] rom_data;
   logic [7:0]  rom_addr;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_fun;
   logic [7:0]  cmd_arg;
   logic        busy, halted;

   logic [15:0] rom [256];
   cmd_t        exp_q[$];
   cmd_t        mon_e;
   int          checks = 0;
   int          errors = 0;

   script_sequencer #(.TICK_W(8), .PC_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .cond(cond), .tick(tick),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_fun(cmd_fun), .cmd_arg(cmd_arg),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected got op=%0d fun=%0d arg=%0h required none",
                     cmd_op, cmd_fun, cmd_arg);
         end else begin
            mon_e = exp_q.pop_front();
            if ({cmd_op, cmd_fun, cmd_arg} !== mon_e) begin
               errors++;
               $display("FAIL cmd_payload got op=%0d fun=%0d arg=%0h required op=%0d fun=%0d arg=%0h",
                        cmd_op, cmd_fun, cmd_arg, mon_e.op, mon_e.fun, mon_e.arg);
            end
         end
      end
   end

   function automatic cmd_t mk(input logic [2:0] op, input logic [1:0] fun, input logic [7:0] arg);
      mk = {op, fun, arg};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic do_reset;
      rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; cmd_ready = 1'b0; cond = 8'h00;
      step;
      step;
      rst = 1'b0;
   endtask

   // Leaves the bench at the first FETCH cycle.
   task automatic start_script;
      start = 1'b1;
      step;
      start = 1'b0;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 200) begin
         step;
         cyc++;
      end
   endtask

   // Straight script interpreter: commands in order, final pc.
   function automatic logic [7:0] model_run();
      logic [7:0]  pc;
      logic [15:0] w;
      logic [2:0]  op;
      logic [1:0]  fn;
      logic [7:0]  num;
      logic        taken;
      pc = 8'd0;
      for (int n = 0; n < 300; n++) begin
         w = rom[pc];
         num = w[15:8]; fn = w[4:3]; op = w[2:0];
         if (op == 3'd0) return pc;
         if (op == 3'd1 || (op == 3'd4 && fn < 2'd2)) begin
            exp_q.push_back(mk(op, fn, num));
            pc = pc + 8'd1;
            if (op == 3'd4 && fn == 2'd1) return pc;
         end else if (op == 3'd2) begin
            taken = (fn == 2'd2) || (fn == 2'd0 && cond[w[7:5]]) || (fn == 2'd1 && !cond[w[7:5]]);
            pc = taken ? num : pc + 8'd1;
         end else begin
            pc = pc + 8'd1;
         end
      end
      return pc;
   endfunction

   task automatic gen_prog;
      logic [2:0] op, isg;
      logic [1:0] fn;
      logic [7:0] num;
      for (int a = 0; a < 23; a++) begin
         op  = 3'($urandom_range(1, 7));
         fn  = 2'($urandom_range(0, 3));
         isg = 3'($urandom_range(0, 7));
         num = 8'($urandom_range(0, 255));
         if (op == 3'd2) num = 8'($urandom_range(a + 1, 23));
         if (op == 3'd3) begin
            if (fn == 2'd0)      num = 8'($urandom_range(0, 3));
            else if (fn != 2'd3) fn = cond[isg] ? 2'b01 : 2'b10;
         end
         rom[a] = {num, isg, fn, op};
      end
      rom[23] = 16'h0000;
   endtask

   logic [7:0]  exp_pc;
   logic [15:0] wc_word [2];
   logic [7:0]  wc_hold [2];
   logic [7:0]  wc_go [2];
   logic [15:0] wrap_word [2];
   int          cyc, nvalid;

   initial begin
      // Action then halt, ready tied high.
      clear_rom;
      rom[0] = 16'h0501;
      do_reset;
      chk("reset_state", {rom_addr, cmd_valid, cmd_op, cmd_fun, cmd_arg, busy, halted}, 0);
      cmd_ready = 1'b1;
      exp_q.push_back(mk(3'b001, 2'b00, 8'h05));
      start_script;
      chk("busy_after_start", busy, 1);
      nvalid = 0;
      cyc = 0;
      while (!halted && cyc < 50) begin
         if (cmd_valid) nvalid++;
         step;
         cyc++;
      end
      chk("action_valid_cycles", nvalid, 1);
      chk("action_halted", halted, 1);
      chk("action_final_pc", rom_addr, 8'h01);
      chk("busy_in_halt", busy, 0);

      // Backpressure: fields frozen while ready is low.
      clear_rom;
      rom[0] = 16'h2A09;
      do_reset;
      exp_q.push_back(mk(3'b001, 2'b01, 8'h2A));
      start_script;
      cyc = 0;
      while (!cmd_valid && cyc < 20) begin
         step;
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {cmd_valid, cmd_op, cmd_fun, cmd_arg, rom_addr}, {1'b1, 3'b001, 2'b01, 8'h2A, 8'h00});
         if (i == 4) cmd_ready = 1'b1;
         step;
      end
      chk("bp_after_accept", {cmd_valid, rom_addr}, {1'b0, 8'h01});
      run_to_halt(cyc);
      chk("bp_halted", halted, 1);
      chk("queue_drained", exp_q.size(), 0);

      // Conditional jump at address 2 on cond[1], reached by an unconditional jump.
      for (int c = 0; c < 2; c++) begin
         clear_rom;
         rom[0] = 16'h0212;
         rom[2] = 16'h0A22;
         do_reset;
         cond = (c == 1) ? 8'h02 : 8'hFD;
         start_script;
         run_to_halt(cyc);
         chk("jump_cycles", cyc, 6);
         chk("jump_dest", rom_addr, (c == 1) ? 8'd10 : 8'd3);
      end

      // pc 255 to 0 by jump and by increment wrap, then stop while fetching.
      wrap_word[0] = 16'h0012;
      wrap_word[1] = 16'h0003;
      for (int v = 0; v < 2; v++) begin
         clear_rom;
         rom[0]   = 16'hFF12;
         rom[255] = wrap_word[v];
         do_reset;
         start_script;
         step;
         step;
         chk("wrap_at_255", rom_addr, 8'hFF);
         step;
         step;
         chk("wrap_to_0", {busy, rom_addr}, {1'b1, 8'h00});
         stop = 1'b1;
         step;
         stop = 1'b0;
         chk("stop_in_fetch", {busy, halted}, 2'b00);
      end

      // Stop while executing holds the pc.
      clear_rom;
      rom[0] = 16'h0412;
      rom[4] = 16'h0501;
      do_reset;
      start_script;
      step;
      step;
      step;
      stop = 1'b1;
      step;
      stop = 1'b0;
      chk("stop_in_exec", {busy, rom_addr, cmd_valid}, {1'b0, 8'h04, 1'b0});

      // Timed wait of 3 ticks, a tick during EXEC ignored.
      clear_rom;
      rom[0] = 16'h0303;
      do_reset;
      start_script;
      for (int k = 1; k <= 18; k++) begin
         if (k == 15) chk("wait_t_before_last", {busy, rom_addr}, {1'b1, 8'h00});
         if (k == 16) chk("wait_t_fetch", {busy, rom_addr}, {1'b1, 8'h01});
         if (k == 18) chk("wait_t_halted", halted, 1);
         tick = (k == 2 || k == 5 || k == 10 || k == 15);
         step;
      end
      tick = 1'b0;

      // Zero-length timed wait.
      clear_rom;
      rom[0] = 16'h0003;
      do_reset;
      start_script;
      step;
      step;
      step;
      chk("wait0_fetch", {halted, rom_addr}, {1'b0, 8'h01});
      step;
      chk("wait0_halted", halted, 1);

      // Condition waits on cond[3], both polarities.
      wc_word[0] = 16'h006B; wc_hold[0] = 8'hF7; wc_go[0] = 8'h08;
      wc_word[1] = 16'h0073; wc_hold[1] = 8'h08; wc_go[1] = 8'hF7;
      for (int w = 0; w < 2; w++) begin
         clear_rom;
         rom[0] = wc_word[w];
         do_reset;
         cond = wc_hold[w];
         start_script;
         for (int k = 1; k <= 12; k++) begin
            if (k == 9)  chk("wait_c_stalled", {busy, rom_addr}, {1'b1, 8'h00});
            if (k == 10) chk("wait_c_fetch", rom_addr, 8'h01);
            if (k == 12) chk("wait_c_halted", halted, 1);
            if (k == 9) cond = wc_go[w];
            step;
         end
      end

      // Condition already satisfied: one WAIT_C cycle.
      clear_rom;
      rom[0] = 16'h006B;
      do_reset;
      cond = 8'h08;
      start_script;
      step;
      step;
      chk("wait_c_first_cycle", rom_addr, 8'h00);
      step;
      chk("wait_c_immediate", rom_addr, 8'h01);

      // Stop during a timed wait.
      clear_rom;
      rom[0] = 16'h0503;
      do_reset;
      start_script;
      step;
      step;
      step;
      stop = 1'b1;
      step;
      stop = 1'b0;
      chk("stop_wait_t", {busy, halted, rom_addr}, {1'b0, 1'b0, 8'h00});
      start = 1'b1;
      stop  = 1'b1;
      step;
      start = 1'b0;
      stop  = 1'b0;
      chk("stop_beats_start", busy, 0);

      // Stop during ISSUE keeps the handshake alive until accepted.
      clear_rom;
      rom[0] = 16'h0701;
      rom[1] = 16'h0501;
      do_reset;
      exp_q.push_back(mk(3'b001, 2'b00, 8'h07));
      start_script;
      step;
      step;
      chk("issue_valid", cmd_valid, 1);
      stop = 1'b1;
      step;
      stop = 1'b0;
      chk("issue_hold_after_stop", cmd_valid, 1);
      step;
      chk("issue_hold_2", cmd_valid, 1);
      cmd_ready = 1'b1;
      step;
      chk("issue_stop_idle", {cmd_valid, busy, halted, rom_addr}, {1'b0, 1'b0, 1'b0, 8'h01});
      step;
      step;
      chk("issue_stop_stays_idle", {busy, cmd_valid}, 2'b00);

      // End-game Game State command halts.
      clear_rom;
      rom[0] = 16'h330C;
      rom[1] = 16'h0501;
      do_reset;
      cmd_ready = 1'b1;
      exp_q.push_back(mk(3'b100, 2'b01, 8'h33));
      start_script;
      step;
      step;
      step;
      chk("end_game", {halted, busy, cmd_valid, rom_addr}, {1'b1, 1'b0, 1'b0, 8'h01});
      chk("queue_drained_directed", exp_q.size(), 0);

      // Reset while a command is pending.
      clear_rom;
      rom[0] = 16'h0701;
      do_reset;
      start_script;
      step;
      step;
      rst = 1'b1;
      step;
      chk("reset_mid_issue", {rom_addr, cmd_valid, cmd_op, cmd_fun, cmd_arg, busy, halted}, 0);
      rst = 1'b0;

      // Random scripts against the interpreter.
      for (int p = 0; p < 40; p++) begin
         clear_rom;
         do_reset;
         cond = 8'($urandom);
         gen_prog;
         exp_pc = model_run();
         start_script;
         cyc = 0;
         while (!halted && cyc < 4000) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            tick      = 1'($urandom_range(0, 1));
            step;
            cyc++;
         end
         tick = 1'b0;
         chk("rand_halted", halted, 1);
         chk("rand_final_pc", rom_addr, exp_pc);
         chk("rand_drained", exp_q.size(), 0);
         exp_q.delete();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
